// File: rtl/fifo_access_arbiter.sv
// fifo_access_arbiter: bursts single-port FIFO pushes/pops between NUM_WR writers and one reader
module fifo_access_arbiter #(
  parameter int NUM_WR     = 4,
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 3,
  parameter int BURST_LEN  = 4
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [NUM_WR-1:0]            wr_req,
  input  logic [NUM_WR*DATA_WIDTH-1:0] wr_data,
  output logic [NUM_WR-1:0]            wr_gnt,
  input  logic                         rd_req,
  output logic                         rd_gnt,
  output logic                         rd_valid,
  output logic [DATA_WIDTH-1:0]        rd_data,
  output logic [ADDR_WIDTH:0]          level,
  output logic                         fifo_en,
  output logic                         fifo_push_pop,
  output logic [DATA_WIDTH-1:0]        fifo_din,
  input  logic [DATA_WIDTH-1:0]        fifo_dout,
  input  logic                         fifo_full,
  input  logic                         fifo_empty
);
  localparam int IW = $clog2(NUM_WR);
  localparam int BW = $clog2(BURST_LEN + 1);
  typedef enum logic [1:0] {IDLE, WR, RD} state_t;
  state_t        state;
  logic [IW-1:0] owner, rr_ptr, pick, wr_idx;
  logic [BW-1:0] burst_cnt;
  logic          last_wr;
  logic          w_ok, r_ok, room, cont_wr, cont_rd, fresh_wr, fresh_rd, do_wr, do_rd;
  always_comb begin
    pick = '0;
    for (int k = NUM_WR - 1; k >= 0; k--)
      if (wr_req[(int'(rr_ptr) + k) % NUM_WR]) pick = IW'((int'(rr_ptr) + k) % NUM_WR);
  end
  assign w_ok     = |wr_req & !fifo_full;
  assign r_ok     = rd_req & !fifo_empty;
  assign room     = burst_cnt < BW'(BURST_LEN);
  assign cont_wr  = state == WR && wr_req[owner] && !fifo_full && room;
  assign cont_rd  = state == RD && r_ok && room;
  // On a tie the class that did not own the last burst wins
  assign fresh_wr = !cont_wr && !cont_rd && w_ok && (!r_ok || !last_wr);
  assign fresh_rd = !cont_wr && !cont_rd && r_ok && (!w_ok || last_wr);
  assign do_wr    = !reset && (cont_wr || fresh_wr);
  assign do_rd    = !reset && (cont_rd || fresh_rd);
  assign wr_idx   = cont_wr ? owner : pick;
  assign wr_gnt   = do_wr ? NUM_WR'(1) << wr_idx : '0;
  assign rd_gnt   = do_rd;
  assign fifo_en  = do_wr || do_rd;
  assign fifo_push_pop = do_wr;
  assign fifo_din = do_wr ? wr_data[int'(wr_idx)*DATA_WIDTH +: DATA_WIDTH] : '0;
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      owner     <= '0;
      burst_cnt <= '0;
      rr_ptr    <= '0;
      last_wr   <= 1'b0;
      level     <= '0;
      rd_valid  <= 1'b0;
      rd_data   <= '0;
    end else begin
      if (cont_wr || cont_rd) begin
        burst_cnt <= burst_cnt + 1'b1;
      end else if (fresh_wr) begin
        state     <= WR;
        owner     <= pick;
        burst_cnt <= BW'(1);
        rr_ptr    <= (pick == IW'(NUM_WR - 1)) ? '0 : pick + 1'b1;
        last_wr   <= 1'b1;
      end else if (fresh_rd) begin
        state     <= RD;
        burst_cnt <= BW'(1);
        last_wr   <= 1'b0;
      end else begin
        state     <= IDLE;
        burst_cnt <= '0;
      end
      level    <= level + (ADDR_WIDTH+1)'(do_wr) - (ADDR_WIDTH+1)'(do_rd);
      rd_valid <= do_rd;
      if (do_rd) rd_data <= fifo_dout;
    end
  end
endmodule

// File: tb/tb_fifo_access_arbiter.sv
// tb_fifo_access_arbiter: directed checks of the arbiter against a behavioural single-port FIFO
module tb_fifo_access_arbiter;
  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  wr_req;
  logic [31:0] wr_data;
  logic [3:0]  wr_gnt;
  logic        rd_req, rd_gnt, rd_valid;
  logic [7:0]  rd_data;
  logic [3:0]  level;
  logic        fifo_en, fifo_push_pop;
  logic [7:0]  fifo_din, fifo_dout;
  logic        fifo_full, fifo_empty;
  int          compared = 0;
  int          mismatched = 0;
  int          lvl;
  logic        wr;
  fifo_access_arbiter #(.NUM_WR(4), .DATA_WIDTH(8), .ADDR_WIDTH(3), .BURST_LEN(4)) dut (
    .clk(clk), .reset(reset), .wr_req(wr_req), .wr_data(wr_data), .wr_gnt(wr_gnt),
    .rd_req(rd_req), .rd_gnt(rd_gnt), .rd_valid(rd_valid), .rd_data(rd_data), .level(level),
    .fifo_en(fifo_en), .fifo_push_pop(fifo_push_pop), .fifo_din(fifo_din),
    .fifo_dout(fifo_dout), .fifo_full(fifo_full), .fifo_empty(fifo_empty)
  );
  always #5 clk = ~clk;
  logic [7:0] mem [8];
  logic [2:0] wp, rp;
  logic [3:0] cnt;
  logic [3:0] wc [4];
  always @(posedge clk) begin
    if (reset) begin
      wp <= '0;
      rp <= '0;
      cnt <= '0;
    end else if (fifo_en) begin
      if (fifo_push_pop) begin
        mem[wp] <= fifo_din;
        wp <= wp + 1'b1;
        cnt <= cnt + 1'b1;
      end else begin
        rp <= rp + 1'b1;
        cnt <= cnt - 1'b1;
      end
    end
  end
  assign fifo_dout  = mem[rp];
  assign fifo_full  = cnt == 4'd8;
  assign fifo_empty = cnt == 4'd0;
  // Each writer offers base+n, where n counts its own accepted words
  always @(posedge clk)
    for (int i = 0; i < 4; i++) wc[i] <= reset ? 4'd0 : wc[i] + 4'(wr_gnt[i]);
  assign wr_data = {8'hD0 + 8'(wc[3]), 8'hC0 + 8'(wc[2]), 8'hB0 + 8'(wc[1]), 8'hA0 + 8'(wc[0])};
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask
  function automatic logic [7:0] word(input int c);
    return c < 4 ? 8'hA0 + 8'(c) : 8'hC0 + 8'(c - 4);
  endfunction
  initial begin
    reset = 1'b1; wr_req = '0; rd_req = 1'b0;
    repeat (2) next_cycle();
    wr_req = 4'b0101;
    @(negedge clk);
    chk("rst_wr_gnt", wr_gnt, 0);
    chk("rst_fifo_en", fifo_en, 0);
    chk("rst_level", level, 0);
    chk("rst_rd_valid", rd_valid, 0);
    chk("rst_rd_data", rd_data, 0);
    next_cycle();
    reset = 1'b0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      chk("t1_wr_gnt", wr_gnt, c < 4 ? 4'b0001 : 4'b0100);
      chk("t1_din", fifo_din, word(c));
      chk("t1_level", level, c);
      next_cycle();
    end
    @(negedge clk);
    chk("t1_full_gnt", wr_gnt, 0);
    chk("t1_full_en", fifo_en, 0);
    chk("t1_full_level", level, 8);
    next_cycle();
    wr_req = '0; rd_req = 1'b1;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      chk("t2_rd_gnt", rd_gnt, 1);
      chk("t2_push_pop", fifo_push_pop, 0);
      chk("t2_rd_valid", rd_valid, c > 0);
      if (c > 0) chk("t2_rd_data", rd_data, word(c - 1));
      chk("t2_level", level, 8 - c);
      next_cycle();
    end
    @(negedge clk);
    chk("t2_empty_gnt", rd_gnt, 0);
    chk("t2_empty_en", fifo_en, 0);
    chk("t2_last_valid", rd_valid, 1);
    chk("t2_last_data", rd_data, 8'hC3);
    chk("t2_empty_level", level, 0);
    next_cycle();
    @(negedge clk);
    chk("t2_valid_drop", rd_valid, 0);
    next_cycle();
    rd_req = 1'b0; wr_req = 4'b0010;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("t3_pre_wr", wr_gnt, 4'b0010);
      next_cycle();
    end
    wr_req = '0; rd_req = 1'b1;
    @(negedge clk);
    chk("t3_pre_rd", rd_gnt, 1);
    next_cycle();
    rd_req = 1'b0;
    next_cycle();
    wr_req = 4'b0010; rd_req = 1'b1; lvl = 2;
    for (int c = 0; c < 16; c++) begin
      wr = ((c / 4) % 2) == 0;
      @(negedge clk);
      chk("t3_en", fifo_en, 1);
      chk("t3_push_pop", fifo_push_pop, wr);
      chk("t3_wr_gnt", wr_gnt, wr ? 4'b0010 : 4'b0000);
      chk("t3_level", level, lvl);
      lvl = wr ? lvl + 1 : lvl - 1;
      next_cycle();
    end
    wr_req = 4'b1000; rd_req = 1'b0;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      chk("t4_w3_gnt", wr_gnt, 4'b1000);
      next_cycle();
    end
    wr_req = '0; rd_req = 1'b1;
    @(negedge clk);
    chk("t4_rd_gnt", rd_gnt, 1);
    chk("t4_wr_gnt", wr_gnt, 0);
    chk("t4_level", level, 4);
    next_cycle();
    rd_req = 1'b0; wr_req = 4'b0101;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      chk("t5_w0_gnt", wr_gnt, 4'b0001);
      next_cycle();
    end
    reset = 1'b1; rd_req = 1'b1;
    @(negedge clk);
    chk("t5_rst_wr_gnt", wr_gnt, 0);
    chk("t5_rst_rd_gnt", rd_gnt, 0);
    chk("t5_rst_en", fifo_en, 0);
    chk("t5_rst_din", fifo_din, 0);
    next_cycle();
    reset = 1'b0;
    @(negedge clk);
    chk("t5_level", level, 0);
    chk("t5_rd_valid", rd_valid, 0);
    chk("t5_first_gnt", wr_gnt, 4'b0001);
    chk("t5_first_push", fifo_push_pop, 1);
    next_cycle();
    reset = 1'b1;
    next_cycle();
    reset = 1'b0; wr_req = '0; rd_req = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("t6_rd_gnt", rd_gnt, 0);
      chk("t6_en", fifo_en, 0);
      chk("t6_rd_valid", rd_valid, 0);
      chk("t6_level", level, 0);
      next_cycle();
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
